// File: rtl/shift_ctrl.sv
// shift_ctrl: bit-serial shifter, one bit per clock, valid/ready on both sides.
// Supports SLL, SRL and SRA by 0..WIDTH-1, plus PASS. Only one request is in flight at a time.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   flush              synchronous abort of the operation in progress, back to IDLE
//   in_valid/in_ready  request handshake; in_ready is high only in IDLE
//   in_op              00 SLL, 01 SRL, 10 SRA, 11 PASS
//   in_data, in_shamt  operand and shift amount
//   out_valid/ready    result handshake; out_valid is high only in DONE
//   out_data           registered result (accumulator)
//   busy               high in SHIFT or DONE

module shift_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [SHW-1:0] CNT_ONE =
    {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic [1:0]       op, op_n;
  logic [WIDTH-1:0] acc_step;

  // One-bit step of the accumulator. SRA keeps the MSB, which is
  // the latched operand's sign bit, since the MSB never changes.
  always_comb begin
    acc_step = acc;
    unique case (op)
      OP_SLL:  acc_step = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_step = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
      OP_PASS: acc_step = acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op    <= OP_SLL;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      op    <= op_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    op_n    = op;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_n  = in_op;
            acc_n = in_data;
            if (in_op == OP_PASS || in_shamt == '0) begin
              state_n = DONE;
              cnt_n   = '0;
            end else begin
              state_n = SHIFT;
              cnt_n   = in_shamt;
            end
          end
        end
        SHIFT: begin
          acc_n = acc_step;
          cnt_n = cnt - CNT_ONE;
          if (cnt == CNT_ONE)
            state_n = DONE;
        end
        DONE: begin
          if (out_ready)
            state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = acc;

endmodule
